// File: rtl/timer_irq_pkg.sv
// Shared types and constants for the timer interrupt controller.
// Optional event counters are enabled by defining TIMER_IRQ_CNT_EN.
package timer_irq_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [1:0] NONE     = 2'd0;
    localparam logic [1:0] ONE_SHOT = 2'd1;
    localparam logic [1:0] PERIODIC = 2'd2;
    localparam logic [1:0] PWM      = 2'd3;

    localparam int SRC_ONE_SHOT = 0;
    localparam int SRC_PERIODIC = 1;
    localparam int SRC_PWM      = 2;
    localparam int NUM_SRC      = 3;

    localparam int CNT_W = 16;

    // One-shot wins over periodic, periodic over pwm.
    function automatic logic [1:0] prio_id(input logic [2:0] req);
        logic [1:0] id;
        id = NONE;
        priority case (1'b1)
            req[SRC_ONE_SHOT]: id = ONE_SHOT;
            req[SRC_PERIODIC]: id = PERIODIC;
            req[SRC_PWM]:      id = PWM;
            default:           id = NONE;
        endcase
        return id;
    endfunction

    function automatic logic [2:0] id_bit(input logic [1:0] id);
        logic [2:0] b;
        b = '0;
        unique case (id)
            ONE_SHOT: b[SRC_ONE_SHOT] = 1'b1;
            PERIODIC: b[SRC_PERIODIC] = 1'b1;
            PWM:      b[SRC_PWM]      = 1'b1;
            default:  b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/irq_edge_det.sv
// Registers one interrupt source and flags a sampled rising edge.
module irq_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic smp;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp  <= 1'b0;
            prev <= 1'b0;
        end else begin
            smp  <= level;
            prev <= smp;
        end
    end

    assign rise = smp & ~prev;

endmodule

// File: rtl/timer_irq_ctrl.sv
// Interrupt aggregator for the multi-mode timer sources.
// Define TIMER_IRQ_CNT_EN to add per-source saturating event counters.
module timer_irq_ctrl
    import timer_irq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        one_shot_irq,
    input  logic        periodic_irq,
    input  logic        pwm_irq,
    input  logic [2:0]  irq_mask,
    input  logic        ack_valid,
    input  logic [1:0]  ack_id,
`ifdef TIMER_IRQ_CNT_EN
    input  logic [1:0]  cnt_sel,
    output logic [15:0] cnt_out,
`endif
    output logic        irq_out,
    output logic [1:0]  irq_id,
    output logic [2:0]  pending,
    output logic [2:0]  overflow,
    output logic        ack_err
);

    logic [2:0] src;
    logic [2:0] ev;

    assign src = {pwm_irq, periodic_irq, one_shot_irq};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_edge
        irq_edge_det u_edge (
            .clk   (clk),
            .rst   (rst),
            .level (src[i]),
            .rise  (ev[i])
        );
    end

    state_t     state;
    state_t     state_n;
    logic [1:0] id_n;
    logic       ack_ok;
    logic [2:0] ack_vec;
    logic [2:0] req;

    assign ack_ok  = ack_valid && (state == ACTIVE) && (ack_id == irq_id);
    assign ack_vec = ack_ok ? id_bit(irq_id) : 3'b000;
    assign req     = pending & ~irq_mask;
    assign irq_out = (state == ACTIVE);

    always_comb begin
        state_n = state;
        id_n    = irq_id;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_n = ACTIVE;
                    id_n    = prio_id(req);
                end
            end
            ACTIVE: begin
                if (ack_ok) begin
                    state_n = IDLE;
                    id_n    = NONE;
                end
            end
            default: begin
                state_n = IDLE;
                id_n    = NONE;
            end
        endcase
    end

    // A new event on the source being acked keeps it pending but drops overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            irq_id   <= NONE;
            pending  <= '0;
            overflow <= '0;
            ack_err  <= 1'b0;
        end else begin
            state    <= state_n;
            irq_id   <= id_n;
            pending  <= ev | (pending & ~ack_vec);
            overflow <= (overflow | (ev & pending)) & ~ack_vec;
            ack_err  <= ack_valid && !ack_ok;
        end
    end

`ifdef TIMER_IRQ_CNT_EN
    logic [CNT_W-1:0] cnt [NUM_SRC];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (ev[i] && (cnt[i] != '1)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        cnt_out = '0;
        case (cnt_sel)
            2'd1:    cnt_out = cnt[SRC_ONE_SHOT];
            2'd2:    cnt_out = cnt[SRC_PERIODIC];
            2'd3:    cnt_out = cnt[SRC_PWM];
            default: cnt_out = '0;
        endcase
    end
`endif

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Scoreboard bench for timer_irq_ctrl; counter checks run when
// TIMER_IRQ_CNT_EN is defined.
module tb_timer_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       one_shot_irq = 1'b0;
    logic       periodic_irq = 1'b0;
    logic       pwm_irq = 1'b0;
    logic [2:0] irq_mask = 3'b000;
    logic       ack_valid = 1'b0;
    logic [1:0] ack_id = 2'd0;
    logic       irq_out;
    logic [1:0] irq_id;
    logic [2:0] pending;
    logic [2:0] overflow;
    logic       ack_err;
`ifdef TIMER_IRQ_CNT_EN
    logic [1:0]  cnt_sel = 2'd0;
    logic [15:0] cnt_out;
`endif

    always #5 clk = ~clk;

    timer_irq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .one_shot_irq (one_shot_irq),
        .periodic_irq (periodic_irq),
        .pwm_irq      (pwm_irq),
        .irq_mask     (irq_mask),
        .ack_valid    (ack_valid),
        .ack_id       (ack_id),
`ifdef TIMER_IRQ_CNT_EN
        .cnt_sel      (cnt_sel),
        .cnt_out      (cnt_out),
`endif
        .irq_out      (irq_out),
        .irq_id       (irq_id),
        .pending      (pending),
        .overflow     (overflow),
        .ack_err      (ack_err)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        bit          is_cnt;
        logic [15:0] exp;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Packed status: {irq_out, irq_id, pending, overflow, ack_err}
    function automatic logic [15:0] st(input logic o, input logic [1:0] id,
                                       input logic [2:0] p,
                                       input logic [2:0] ov,
                                       input logic e);
        return {6'b0, o, id, p, ov, e};
    endfunction

    task automatic exp_st(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.is_cnt = 1'b0;
        e.exp = v;
        sbq.push_back(e);
    endtask

    task automatic exp_cnt(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.is_cnt = 1'b1;
        e.exp = v;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [15:0] got;
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            got = {6'b0, irq_out, irq_id, pending, overflow, ack_err};
`ifdef TIMER_IRQ_CNT_EN
            if (e.is_cnt) got = cnt_out;
`endif
            chk(e.tag, got, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        drain();
    endtask

    task automatic ack(input logic [1:0] id);
        ack_valid = 1'b1;
        ack_id = id;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded", $time);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            exp_st("reset", st(0, 0, 3'b000, 3'b000, 0));
            tick();
        end
        rst = 1'b0;

        // single one-shot pulse
        one_shot_irq = 1'b1;
        exp_st("os_sample", st(0, 0, 3'b000, 3'b000, 0));
        tick();
        one_shot_irq = 1'b0;
        exp_st("os_pend", st(0, 0, 3'b001, 3'b000, 0));
        tick();
        exp_st("os_active", st(1, 1, 3'b001, 3'b000, 0));
        tick();
        ack(2'd1);
        exp_st("os_ack", st(0, 0, 3'b000, 3'b000, 0));
        tick();
        ack_valid = 1'b0;

        // periodic and pwm together
        periodic_irq = 1'b1;
        pwm_irq = 1'b1;
        exp_st("pp_sample", st(0, 0, 3'b000, 3'b000, 0));
        tick();
        periodic_irq = 1'b0;
        pwm_irq = 1'b0;
        exp_st("pp_pend", st(0, 0, 3'b110, 3'b000, 0));
        tick();
        exp_st("pp_per", st(1, 2, 3'b110, 3'b000, 0));
        tick();
        ack(2'd2);
        exp_st("pp_idle", st(0, 0, 3'b100, 3'b000, 0));
        tick();
        ack_valid = 1'b0;
        exp_st("pp_pwm", st(1, 3, 3'b100, 3'b000, 0));
        tick();
        ack(2'd3);
        exp_st("pp_done", st(0, 0, 3'b000, 3'b000, 0));
        tick();
        ack_valid = 1'b0;

        // masked one-shot, then wrong ack and ack in idle
        irq_mask = 3'b001;
        one_shot_irq = 1'b1;
        exp_st("msk_sample", st(0, 0, 3'b000, 3'b000, 0));
        tick();
        one_shot_irq = 1'b0;
        exp_st("msk_pend", st(0, 0, 3'b001, 3'b000, 0));
        tick();
        exp_st("msk_hold", st(0, 0, 3'b001, 3'b000, 0));
        tick();
        irq_mask = 3'b000;
        exp_st("msk_clear", st(1, 1, 3'b001, 3'b000, 0));
        tick();
        irq_mask = 3'b111;
        ack(2'd2);
        exp_st("bad_ack", st(1, 1, 3'b001, 3'b000, 1));
        tick();
        ack_valid = 1'b0;
        irq_mask = 3'b000;
        exp_st("bad_ack_end", st(1, 1, 3'b001, 3'b000, 0));
        tick();
        ack(2'd1);
        exp_st("os_ack2", st(0, 0, 3'b000, 3'b000, 0));
        tick();
        exp_st("idle_ack", st(0, 0, 3'b000, 3'b000, 1));
        tick();
        ack_valid = 1'b0;
        exp_st("idle_ack_end", st(0, 0, 3'b000, 3'b000, 0));
        tick();

        // two periodic edges before ack
        periodic_irq = 1'b1;
        exp_st("ovf_sample", st(0, 0, 3'b000, 3'b000, 0));
        tick();
        periodic_irq = 1'b0;
        exp_st("ovf_pend", st(0, 0, 3'b010, 3'b000, 0));
        tick();
        periodic_irq = 1'b1;
        exp_st("ovf_active", st(1, 2, 3'b010, 3'b000, 0));
        tick();
        periodic_irq = 1'b0;
        exp_st("ovf_set", st(1, 2, 3'b010, 3'b010, 0));
        tick();
        ack(2'd2);
        exp_st("ovf_ack", st(0, 0, 3'b000, 3'b000, 0));
        tick();
        ack_valid = 1'b0;

        // new event coincides with its own ack
        periodic_irq = 1'b1;
        exp_st("sw_sample", st(0, 0, 3'b000, 3'b000, 0));
        tick();
        periodic_irq = 1'b0;
        exp_st("sw_pend", st(0, 0, 3'b010, 3'b000, 0));
        tick();
        exp_st("sw_active", st(1, 2, 3'b010, 3'b000, 0));
        tick();
        periodic_irq = 1'b1;
        exp_st("sw_resample", st(1, 2, 3'b010, 3'b000, 0));
        tick();
        periodic_irq = 1'b0;
        ack(2'd2);
        exp_st("sw_setwins", st(0, 0, 3'b010, 3'b000, 0));
        tick();
        ack_valid = 1'b0;
        exp_st("sw_again", st(1, 2, 3'b010, 3'b000, 0));
        tick();
        ack(2'd2);
        exp_st("sw_done", st(0, 0, 3'b000, 3'b000, 0));
        tick();
        ack_valid = 1'b0;

        // reset while active
        periodic_irq = 1'b1;
        pwm_irq = 1'b1;
        tick();
        periodic_irq = 1'b0;
        pwm_irq = 1'b0;
        tick();
        exp_st("rs_active", st(1, 2, 3'b110, 3'b000, 0));
        tick();
        rst = 1'b1;
        #1;
        exp_st("rs_async", st(0, 0, 3'b000, 3'b000, 0));
        drain();
        one_shot_irq = 1'b1;
        exp_st("rs_hold", st(0, 0, 3'b000, 3'b000, 0));
        tick();
        rst = 1'b0;

        // source high across reset release counts once
        exp_st("hi_sample", st(0, 0, 3'b000, 3'b000, 0));
        tick();
        exp_st("hi_pend", st(0, 0, 3'b001, 3'b000, 0));
        tick();
        exp_st("hi_active", st(1, 1, 3'b001, 3'b000, 0));
        tick();
        exp_st("hi_noretrig", st(1, 1, 3'b001, 3'b000, 0));
        tick();
        one_shot_irq = 1'b0;
        ack(2'd1);
        exp_st("hi_ack", st(0, 0, 3'b000, 3'b000, 0));
        tick();
        ack_valid = 1'b0;

`ifdef TIMER_IRQ_CNT_EN
        cnt_sel = 2'd0;
        exp_cnt("cnt_sel0", 16'd0);
        tick();
        cnt_sel = 2'd1;
        exp_cnt("cnt_os", 16'd1);
        tick();
        cnt_sel = 2'd2;
        exp_cnt("cnt_per", 16'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            pwm_irq = 1'b1;
            tick();
            pwm_irq = 1'b0;
            tick();
        end
        cnt_sel = 2'd3;
        exp_cnt("cnt_pwm", 16'd3);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
